parking_lot_ctrl: RTL and testbench
===================================

Name: parking_lot_ctrl

Overview:
- Second-generation parking-lot controller: a single synchronous design replacing edge-triggered entry/exit counting with strobe-in / done-out handshakes.
- Tracks two occupancy classes: uni (reserved priority) and general.
- The hour-of-day schedule for general capacity is a parameter, not hard-coded.
- Sits behind the gate sensors; feeds the display and barrier logic with accept/reject decisions, occupancy and vacancy.

Parameters:
- TOTAL_CAP, 700, total spaces shared by both classes.
- CNT_W, 11, width of every count/vacancy bus; must satisfy 2**CNT_W > TOTAL_CAP.
- TICKS_PER_HOUR, 3600, clk cycles per simulated hour.
- GEN_CAP_SCHED, parking_pkg::DEFAULT_SCHED, packed 24*CNT_W vector; slice h is the general capacity for hour h.
  - Default: hours 0-7 = 500, 8-12 = 200, 13 = 250, 14 = 300, 15 = 350, 16-23 = 500.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- entry_req  in  1  one-cycle strobe: a car requests entry
- entry_is_uni  in  1  class of entering car; sampled with entry_req
- exit_req  in  1  one-cycle strobe: a car has exited
- exit_is_uni  in  1  class of exiting car; sampled with exit_req
- time_set  in  1  load hour_in into the clock
- hour_in  in  5  hour to load (0-23)
- entry_done  out  1  one-cycle pulse answering entry_req
- entry_ok  out  1  valid with entry_done: 1 = admitted, 0 = rejected
- exit_done  out  1  one-cycle pulse answering exit_req
- exit_err  out  1  valid with exit_done: 1 = exit from an empty class, ignored
- hour  out  5  current hour
- uni_parked  out  CNT_W  uni cars inside
- gen_parked  out  CNT_W  general cars inside
- uni_vacated  out  CNT_W  spaces available to a uni car
- gen_vacated  out  CNT_W  spaces available to a general car
- uni_has_space  out  1  uni_vacated != 0
- gen_has_space  out  1  gen_vacated != 0

Behaviour:
- Reset (synchronous, active-high):
  - tick = 0, hour = 0, uni_parked = gen_parked = 0.
  - entry_done, entry_ok, exit_done and exit_err are all 0.
  - Vacancy outputs follow from state: uni_vacated = TOTAL_CAP, gen_vacated = sched[0] (500 by default).
  - A strobe asserted in the same cycle as rst is dropped: no done pulse is produced.
- Clock:
  - tick counts 0..TICKS_PER_HOUR-1.
  - At tick == TICKS_PER_HOUR-1: tick returns to 0 and hour increments, wrapping 23 -> 0.
  - time_set: hour <= hour_in (values >23 are clamped to 23), tick <= 0. time_set has priority over the tick increment.
- Capacity: cap = GEN_CAP_SCHED slice[hour], where hour is the registered value.
- Vacancy (combinational from registered state):
  - uni_vacated = TOTAL_CAP - uni_parked - gen_parked.
  - If uni_parked > TOTAL_CAP - cap (uni cars have spilled into the general region): gen_vacated = uni_vacated.
  - Else: gen_vacated = cap - gen_parked when cap > gen_parked, otherwise 0.
- Handshake latency:
  - A strobe in cycle N produces the done pulse in cycle N+1.
  - Updated counts are also visible in cycle N+1.
  - Back-to-back strobes every cycle must be supported.
- Entry decision (cycle N):
  - Uses the vacancy at the start of cycle N.
  - A uni car is admitted iff uni_vacated > 0; a general car is admitted iff gen_vacated > 0.
  - On admit, the class count increments; on reject, counts are unchanged.
- Exit decision:
  - If the class count > 0, it decrements and exit_err = 0.
  - Otherwise counts are unchanged and exit_err = 1. Counts never underflow.
- Simultaneous entry and exit in the same cycle:
  - Both are resolved independently against pre-cycle state, so an exit does not free space for a same-cycle entry.
  - Both count updates are applied, giving a net change of 0 for the same class.
- Capacity shrink at an hour boundary:
  - Parked cars are never evicted.
  - gen_vacated clamps to 0 and further general entries are rejected until occupancy falls below cap.
- Invariant (checked by an assertion): uni_parked + gen_parked <= TOTAL_CAP.

Decomposition:
- parking_pkg holds:
  - HOURS_PER_DAY = 24 and HOUR_W = 5.
  - DEFAULT_SCHED constant.
  - Function cap_of_hour(sched, hour).
- Sub-module parking_clock contains the tick/hour counter with time_set and outputs hour.
- parking_lot_ctrl holds the occupancy registers, the entry/exit decision and the vacancy logic.

Test Plan:
- Reset, then idle: uni_parked = gen_parked = 0, uni_vacated = 700, gen_vacated = 500, hour = 0, has_space both 1.
- time_set with hour_in = 9, then 200 general entries (all ok = 1); 201st entry -> entry_ok = 0, gen_vacated = 0, uni entry still ok.
- TICKS_PER_HOUR = 4 build: time_set with hour_in = 12, 250 general cars; after 4 clocks hour = 13 and gen_vacated = 0; after 4 more clocks hour = 14 and gen_vacated = 50; at hour 23, 4 clocks -> hour = 0.
- Uni overflow at hour 9: 600 uni cars parked -> gen_vacated = uni_vacated = 100; fill to 700 total -> both has_space 0, both entry classes rejected.
- Exit_req of a uni car with uni_parked = 0 -> exit_done = 1, exit_err = 1, counts unchanged.
- Same-cycle entry and exit of general cars at gen_vacated = 0 -> entry_ok = 0, exit ok, gen_parked decreases by 1; rst asserted together with entry_req -> no entry_done pulse, all counts 0.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared constants, default general-capacity schedule and lookup helper
package parking_pkg;

  localparam int HOURS_PER_DAY = 24;
  localparam int HOUR_W        = 5;
  localparam int SCHED_W       = 11;

  // Slice h (bits h*SCHED_W +: SCHED_W) is the general capacity for hour h; hour 23 is leftmost.
  localparam logic [HOURS_PER_DAY*SCHED_W-1:0] DEFAULT_SCHED = {
    {8{11'd500}},                        // hours 23..16
    11'd350,                             // hour 15
    11'd300,                             // hour 14
    11'd250,                             // hour 13
    {5{11'd200}},                        // hours 12..8
    {8{11'd500}}                         // hours 7..0
  };

  function automatic logic [SCHED_W-1:0] cap_of_hour(
    input logic [HOURS_PER_DAY*SCHED_W-1:0] sched,
    input logic [HOUR_W-1:0]                hour
  );
    return sched[hour*SCHED_W +: SCHED_W];
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// rtl/parking_lot_ctrl_if.sv - gate-sensor requests, decisions and occupancy/vacancy status
interface parking_lot_ctrl_if
  import parking_pkg::*;
#(
  parameter int CNT_W = SCHED_W
);

  logic              entry_req;
  logic              entry_is_uni;
  logic              exit_req;
  logic              exit_is_uni;
  logic              time_set;
  logic [HOUR_W-1:0] hour_in;

  logic              entry_done;
  logic              entry_ok;
  logic              exit_done;
  logic              exit_err;
  logic [HOUR_W-1:0] hour;
  logic [CNT_W-1:0]  uni_parked;
  logic [CNT_W-1:0]  gen_parked;
  logic [CNT_W-1:0]  uni_vacated;
  logic [CNT_W-1:0]  gen_vacated;
  logic              uni_has_space;
  logic              gen_has_space;

  modport master (
    output entry_req, entry_is_uni, exit_req, exit_is_uni, time_set, hour_in,
    input  entry_done, entry_ok, exit_done, exit_err, hour,
    input  uni_parked, gen_parked, uni_vacated, gen_vacated, uni_has_space, gen_has_space
  );

  modport slave (
    input  entry_req, entry_is_uni, exit_req, exit_is_uni, time_set, hour_in,
    output entry_done, entry_ok, exit_done, exit_err, hour,
    output uni_parked, gen_parked, uni_vacated, gen_vacated, uni_has_space, gen_has_space
  );

endinterface

// File: rtl/parking_clock.sv
// rtl/parking_clock.sv - tick/hour-of-day counter with loadable hour
module parking_clock
  import parking_pkg::*;
#(
  parameter int TICKS_PER_HOUR = 3600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              time_set,
  input  logic [HOUR_W-1:0] hour_in,
  output logic [HOUR_W-1:0] hour
);

  localparam int TICK_W = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_HOUR - 1);
  localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(HOURS_PER_DAY - 1);

  logic [TICK_W-1:0] tick;

  // Advance tick/hour; a time load restarts the hour and wins over the rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
      hour <= '0;
    end else if (time_set) begin
      tick <= '0;
      hour <= (hour_in > LAST_HOUR) ? LAST_HOUR : hour_in;
    end else if (tick == LAST_TICK) begin
      tick <= '0;
      hour <= (hour == LAST_HOUR) ? '0 : hour + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// rtl/parking_lot_ctrl.sv - occupancy tracking, entry/exit decisions and vacancy reporting
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int TOTAL_CAP      = 700,
  parameter int CNT_W          = SCHED_W,
  parameter int TICKS_PER_HOUR = 3600,
  parameter logic [HOURS_PER_DAY*CNT_W-1:0] GEN_CAP_SCHED = DEFAULT_SCHED
) (
  input logic               clk,
  input logic               rst,
  parking_lot_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(TOTAL_CAP);

  logic [HOUR_W-1:0] hour;
  logic [CNT_W-1:0]  cap;
  logic [CNT_W-1:0]  uni_parked, gen_parked;
  logic [CNT_W-1:0]  uni_vac, gen_vac, gen_floor;
  logic              entry_admit, exit_error;
  logic              uni_inc, gen_inc, uni_dec, gen_dec;
  logic              entry_done_q, entry_ok_q, exit_done_q, exit_err_q;

  parking_clock #(
    .TICKS_PER_HOUR (TICKS_PER_HOUR)
  ) u_clock (
    .clk      (clk),
    .rst      (rst),
    .time_set (bus.time_set),
    .hour_in  (bus.hour_in),
    .hour     (hour)
  );

  if (CNT_W == SCHED_W) begin : g_pkg_cap
    assign cap = cap_of_hour(GEN_CAP_SCHED, hour);
  end else begin : g_slice_cap
    assign cap = GEN_CAP_SCHED[hour*CNT_W +: CNT_W];
  end

  // Vacancy: uni cars beyond the uni-only region eat into general space, so general then shares the leftover.
  always_comb begin
    uni_vac   = TOTAL - uni_parked - gen_parked;
    gen_floor = TOTAL - cap;
    gen_vac   = '0;
    if (uni_parked > gen_floor) begin
      gen_vac = uni_vac;
    end else if (cap > gen_parked) begin
      gen_vac = cap - gen_parked;
    end
  end

  // Entry and exit are judged independently against pre-cycle occupancy.
  always_comb begin
    entry_admit = bus.entry_req & (bus.entry_is_uni ? (uni_vac != '0) : (gen_vac != '0));
    exit_error  = bus.exit_req & (bus.exit_is_uni ? (uni_parked == '0) : (gen_parked == '0));
    uni_inc     = entry_admit & bus.entry_is_uni;
    gen_inc     = entry_admit & ~bus.entry_is_uni;
    uni_dec     = bus.exit_req & ~exit_error & bus.exit_is_uni;
    gen_dec     = bus.exit_req & ~exit_error & ~bus.exit_is_uni;
  end

  // Occupancy counters and one-cycle done/result pulses; strobes in a reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      uni_parked   <= '0;
      gen_parked   <= '0;
      entry_done_q <= 1'b0;
      entry_ok_q   <= 1'b0;
      exit_done_q  <= 1'b0;
      exit_err_q   <= 1'b0;
    end else begin
      uni_parked   <= uni_parked + CNT_W'(uni_inc) - CNT_W'(uni_dec);
      gen_parked   <= gen_parked + CNT_W'(gen_inc) - CNT_W'(gen_dec);
      entry_done_q <= bus.entry_req;
      entry_ok_q   <= entry_admit;
      exit_done_q  <= bus.exit_req;
      exit_err_q   <= exit_error;
    end
  end

  assign bus.entry_done    = entry_done_q;
  assign bus.entry_ok      = entry_ok_q;
  assign bus.exit_done     = exit_done_q;
  assign bus.exit_err      = exit_err_q;
  assign bus.hour          = hour;
  assign bus.uni_parked    = uni_parked;
  assign bus.gen_parked    = gen_parked;
  assign bus.uni_vacated   = uni_vac;
  assign bus.gen_vacated   = gen_vac;
  assign bus.uni_has_space = (uni_vac != '0);
  assign bus.gen_has_space = (gen_vac != '0);

  a_total_cap: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, uni_parked} + {1'b0, gen_parked}) <= (CNT_W+1)'(TOTAL_CAP));

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb/tb_parking_lot_ctrl.sv - self-checking bench for parking_lot_ctrl
module tb_parking_lot_ctrl;

  localparam int TOTAL_CAP = 700;
  localparam int CNT_W     = 11;
  localparam int TPH       = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_lot_ctrl_if #(.CNT_W(CNT_W)) bus();

  parking_lot_ctrl #(
    .TOTAL_CAP      (TOTAL_CAP),
    .CNT_W          (CNT_W),
    .TICKS_PER_HOUR (TPH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_tick, m_hour, m_uni, m_gen;
  bit m_edone, m_eok, m_xdone, m_xerr;

  typedef struct {
    bit r, er, eu, xr, xu, ts;
    int hin;
    bit e_edone, e_eok, e_xdone, e_xerr;
    int e_hour, e_uni, e_gen;
  } vec_t;

  vec_t vecs[9];

  function automatic int gen_cap(input int h);
    if (h < 8)   return 500;
    if (h < 13)  return 200;
    if (h == 13) return 250;
    if (h == 14) return 300;
    if (h == 15) return 350;
    return 500;
  endfunction

  function automatic int m_uvac();
    return TOTAL_CAP - m_uni - m_gen;
  endfunction

  function automatic int m_gvac();
    int c;
    c = gen_cap(m_hour);
    if (m_uni > TOTAL_CAP - c) return m_uvac();
    return (c > m_gen) ? c - m_gen : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, er, eu, xr, xu, ts, input int hin);
    int uv, gv, nu, ng;
    if (r) begin
      m_tick = 0; m_hour = 0; m_uni = 0; m_gen = 0;
      m_edone = 0; m_eok = 0; m_xdone = 0; m_xerr = 0;
    end else begin
      uv = m_uvac();
      gv = m_gvac();
      m_edone = er;
      m_eok   = er && (eu ? uv > 0 : gv > 0);
      m_xdone = xr;
      m_xerr  = xr && (xu ? m_uni == 0 : m_gen == 0);
      nu = m_uni;
      ng = m_gen;
      if (m_eok) begin
        if (eu) nu++; else ng++;
      end
      if (xr && !m_xerr) begin
        if (xu) nu--; else ng--;
      end
      if (ts) begin
        m_hour = (hin > 23) ? 23 : hin;
        m_tick = 0;
      end else if (m_tick == TPH - 1) begin
        m_tick = 0;
        m_hour = (m_hour + 1) % 24;
      end else begin
        m_tick++;
      end
      m_uni = nu;
      m_gen = ng;
    end
  endtask

  task automatic check_model();
    check("entry_done", bus.entry_done, m_edone);
    check("entry_ok", bus.entry_ok, m_eok);
    check("exit_done", bus.exit_done, m_xdone);
    check("exit_err", bus.exit_err, m_xerr);
    check("hour", bus.hour, m_hour);
    check("uni_parked", bus.uni_parked, m_uni);
    check("gen_parked", bus.gen_parked, m_gen);
    check("uni_vacated", bus.uni_vacated, m_uvac());
    check("gen_vacated", bus.gen_vacated, m_gvac());
    check("uni_has_space", bus.uni_has_space, m_uvac() != 0);
    check("gen_has_space", bus.gen_has_space, m_gvac() != 0);
  endtask

  task automatic step(input bit r, er, eu, xr, xu, ts, input int hin);
    rst              = r;
    bus.entry_req    = er;
    bus.entry_is_uni = eu;
    bus.exit_req     = xr;
    bus.exit_is_uni  = xu;
    bus.time_set     = ts;
    bus.hour_in      = 5'(hin);
    @(posedge clk);
    model_update(r, er, eu, xr, xu, ts, hin);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int n, input bit eu, input int hin);
    for (int i = 0; i < n; i++) step(0, 1, eu, 0, 0, 1, hin);
  endtask

  initial begin
    rst = 1'b1;
    bus.entry_req = 0; bus.entry_is_uni = 0; bus.exit_req = 0;
    bus.exit_is_uni = 0; bus.time_set = 0; bus.hour_in = '0;

    //          r  er eu xr xu ts hin  ed ok xd xe hour uni gen
    vecs[0] = '{1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   0,  0};
    vecs[1] = '{0, 1, 0, 0, 0, 1, 9,   1, 1, 0, 0, 9,   0,  1};
    vecs[2] = '{0, 0, 0, 1, 1, 1, 30,  0, 0, 1, 1, 23,  0,  1};
    vecs[3] = '{0, 1, 1, 1, 0, 1, 5,   1, 1, 1, 0, 5,   1,  0};
    vecs[4] = '{0, 0, 0, 1, 1, 1, 0,   0, 0, 1, 0, 0,   0,  0};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   0,  0};
    vecs[6] = '{0, 1, 0, 1, 0, 0, 0,   1, 1, 1, 1, 0,   0,  1};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   0,  1};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1,   0,  1};

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].r, vecs[i].er, vecs[i].eu, vecs[i].xr, vecs[i].xu, vecs[i].ts, vecs[i].hin);
      check("vec_entry_done", bus.entry_done, vecs[i].e_edone);
      check("vec_entry_ok", bus.entry_ok, vecs[i].e_eok);
      check("vec_exit_done", bus.exit_done, vecs[i].e_xdone);
      check("vec_exit_err", bus.exit_err, vecs[i].e_xerr);
      check("vec_hour", bus.hour, vecs[i].e_hour);
      check("vec_uni", bus.uni_parked, vecs[i].e_uni);
      check("vec_gen", bus.gen_parked, vecs[i].e_gen);
    end

    // reset then idle
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("idle_uvac", bus.uni_vacated, 700);
    check("idle_gvac", bus.gen_vacated, 500);
    check("idle_hour", bus.hour, 0);
    check("idle_uhs", bus.uni_has_space, 1);
    check("idle_ghs", bus.gen_has_space, 1);

    // hour 9: fill general to 200, then reject
    fill(200, 0, 9);
    check("h9_gen", bus.gen_parked, 200);
    check("h9_gvac", bus.gen_vacated, 0);
    step(0, 1, 0, 0, 0, 1, 9);
    check("h9_201_ok", bus.entry_ok, 0);
    check("h9_201_done", bus.entry_done, 1);
    step(0, 1, 1, 0, 0, 1, 9);
    check("h9_uni_ok", bus.entry_ok, 1);
    // same-cycle general entry and exit with no general space
    step(0, 1, 0, 1, 0, 1, 9);
    check("sim_eok", bus.entry_ok, 0);
    check("sim_xerr", bus.exit_err, 0);
    check("sim_gen", bus.gen_parked, 199);
    // reset with an entry strobe
    step(1, 1, 1, 0, 0, 0, 0);
    check("rst_edone", bus.entry_done, 0);
    check("rst_uni", bus.uni_parked, 0);
    check("rst_gen", bus.gen_parked, 0);

    // capacity schedule across hour boundaries
    fill(250, 0, 0);
    step(0, 0, 0, 0, 0, 1, 12);
    check("h12_gvac", bus.gen_vacated, 0);
    idle(4);
    check("h13_hour", bus.hour, 13);
    check("h13_gvac", bus.gen_vacated, 0);
    idle(4);
    check("h14_hour", bus.hour, 14);
    check("h14_gvac", bus.gen_vacated, 50);
    step(0, 0, 0, 0, 0, 1, 23);
    idle(4);
    check("wrap_hour", bus.hour, 0);

    // uni overflow into general region
    step(1, 0, 0, 0, 0, 0, 0);
    fill(600, 1, 9);
    check("ovf_uvac", bus.uni_vacated, 100);
    check("ovf_gvac", bus.gen_vacated, 100);
    fill(100, 1, 9);
    check("full_uhs", bus.uni_has_space, 0);
    check("full_ghs", bus.gen_has_space, 0);
    step(0, 1, 1, 0, 0, 1, 9);
    check("full_uni_ok", bus.entry_ok, 0);
    step(0, 1, 0, 0, 0, 1, 9);
    check("full_gen_ok", bus.entry_ok, 0);
    check("full_uni", bus.uni_parked, 700);

    // exit from empty uni class
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("empty_xdone", bus.exit_done, 1);
    check("empty_xerr", bus.exit_err, 1);
    check("empty_uni", bus.uni_parked, 0);
    check("empty_gen", bus.gen_parked, 0);

    // randomized traffic against the reference model
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0,
           int'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
